quad_encoder_gen: RTL
=====================

# quad_encoder_gen

Quadrature encoder emulator: turns step commands (direction + count) into a two-phase Gray-code pair (quadA, quadB) with a programmable edge period. It drives the game's paddle/cannon quadrature inputs from push-buttons or a test sequencer, replacing a physical rotary encoder. Every output is registered, so quadA/quadB never glitch and at most one of them changes per clock.

## Interface
- DIV_W, default 16: width of the edge-period divider and of step_period.
- CNT_W, default 8: width of cmd_count and of the remaining-steps counter.

- clk  in  1  system clock, same clock as the VGA/game logic
- reset  in  1  asynchronous, active-high reset
- step_period  in  DIV_W  clocks per quadrature edge; sampled on command accept; 0 is treated as 1
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted on a clock edge where cmd_valid & cmd_ready
- cmd_dir  in  1  1 = up (B leads A), 0 = down (A leads B)
- cmd_count  in  CNT_W  number of quadrature edges to emit
- cmd_abort  in  1  stop the current command immediately
- quadA, quadB  out  1 each  quadrature outputs
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a command completes normally

## Operation
- Phase register p[1:0] maps to {quadA,quadB}: p0=00, p1=01, p2=11, p3=10.
- Up: p increments mod 4 (00→01→11→10→00). Down: p decrements mod 4. Receivers count +1 per edge in the up direction.
- States: IDLE, RUN.
- IDLE: cmd_ready=1, busy=0. On accept with cmd_count≠0: latch dir, rem←cmd_count, per←max(step_period,1), div←per−1, go to RUN. On accept with cmd_count=0: no state change, no edge, no done.
- RUN: each clock, if div=0 then p advances one step in the latched direction, rem←rem−1, div←per−1; otherwise div←div−1. The edge that takes rem from 1 to 0 also pulses done and returns to IDLE.
- cmd_abort in RUN takes priority over everything: no edge in that cycle, no done, return to IDLE, p unchanged. The outputs hold their current levels. cmd_abort in IDLE is ignored, and a command presented in the same cycle is still accepted.
- The phase persists across commands, so a new command continues from the current Gray state (no jump).
- step_period and cmd_dir changes during RUN have no effect; both are latched at accept.
- Arithmetic: div and rem are unsigned, no wrap in normal operation; p wraps mod 4.

## Timing
- Reset values: p=0 (quadA=0, quadB=0), state IDLE, cmd_ready=1, busy=0, done=0, div=0, rem=0.
- Reset mid-RUN aborts immediately, with no done pulse.
- Accept at clock edge T, with P = effective period and N = cmd_count:
  - busy=1 and cmd_ready=0 from T.
  - The k-th output edge occurs at edge T+k·P, for k=1..N.
  - done=1 for exactly one cycle starting at T+N·P. busy=0 and cmd_ready=1 from the same edge.
  - The next command can be accepted at T+N·P+1 at the earliest.
- The minimum spacing between consecutive output changes is P clocks. With P=1, an output changes every clock.
- Abort asserted at edge A: busy=0 and cmd_ready=1 from A. No output change at or after A.

## Test plan
- Reset: assert reset asynchronously mid-clock → quadA=quadB=0, busy=0, cmd_ready=1, done=0 immediately. Release, idle 10 clocks → no output change.
- Up command, step_period=4, cmd_count=5, accepted at T → {A,B} = 01,11,10,00,01 at T+4, T+8, T+12, T+16, T+20. done pulses at T+20 only. busy is high over [T, T+20).
- Down command from phase p1 (01), step_period=1, cmd_count=3 → 00, 10, 11 on three consecutive clocks. A reference decoder fed by quadA/quadB shows net −3.
- Zero cases:
  - step_period=0, cmd_count=2 → same timing as P=1.
  - cmd_count=0 → accepted, busy stays 0, no edge, no done.
- Abort: up, P=3, N=10, abort at T+7 → exactly 2 edges (T+3, T+6), no done, busy=0 from T+7. Phase is held. A following up command with N=1 continues from that phase.
- Back-to-back and random:
  - Hold cmd_valid with alternating up/down N=4 P=2 commands → each accepted one clock after the previous done.
  - Random commands, checked by a reference decoder → final count equals Σ(up)−Σ(down) minus the steps dropped by aborts.
  - Throughout both: at most one of quadA/quadB toggles per clock.

Source files
------------

// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature encoder emulator: step request handshake,
// direction/count/period fields and the abort line.
interface quad_encoder_gen_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;
  logic [DIV_W-1:0] step_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_count,
    output cmd_abort,
    output step_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_abort,
    input  step_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: converts (direction, count) step commands into
// a glitch-free Gray-code pair quadA/quadB with a programmable edge period.
module quad_encoder_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  quad_encoder_gen_if.slave   cmd,
  output logic                quadA,
  output logic                quadB,
  output logic                busy,
  output logic                done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, stateNext;
  logic [1:0]       gray, grayNext;
  logic [CNT_W-1:0] rem, remNext;
  logic [DIV_W-1:0] div, divNext;
  logic [DIV_W-1:0] per, perNext;
  logic             dirLat, dirNext;
  logic             doneNext;

  function automatic logic [DIV_W-1:0] effPeriod(input logic [DIV_W-1:0] sp);
    return (sp == '0) ? DIV_W'(1) : sp;
  endfunction

  // One Gray step; the phase is kept directly in output encoding so that
  // quadA/quadB come straight from flops and only one bit moves per step.
  function automatic logic [1:0] stepGray(input logic [1:0] g, input logic up);
    logic [1:0] n;
    case (g)
      2'b00:   n = up ? 2'b01 : 2'b10;
      2'b01:   n = up ? 2'b11 : 2'b00;
      2'b11:   n = up ? 2'b10 : 2'b01;
      default: n = up ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  always_comb begin
    stateNext = state;
    grayNext  = gray;
    remNext   = rem;
    divNext   = div;
    perNext   = per;
    dirNext   = dirLat;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid && (cmd.cmd_count != '0)) begin
          stateNext = RUN;
          dirNext   = cmd.cmd_dir;
          remNext   = cmd.cmd_count;
          perNext   = effPeriod(cmd.step_period);
          divNext   = effPeriod(cmd.step_period) - DIV_W'(1);
        end
      end
      RUN: begin
        if (cmd.cmd_abort) begin
          stateNext = IDLE;
        end else if (div == '0) begin
          grayNext = stepGray(gray, dirLat);
          remNext  = rem - CNT_W'(1);
          divNext  = per - DIV_W'(1);
          if (rem == CNT_W'(1)) begin
            doneNext  = 1'b1;
            stateNext = IDLE;
          end
        end else begin
          divNext = div - DIV_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gray          <= 2'b00;
      rem           <= '0;
      div           <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state         <= stateNext;
      gray          <= grayNext;
      rem           <= remNext;
      div           <= divNext;
      done          <= doneNext;
      busy          <= (stateNext == RUN);
      cmd.cmd_ready <= (stateNext == IDLE);
    end
  end

  // Latched command fields, only meaningful while RUN
  always_ff @(posedge clk) begin
    per    <= perNext;
    dirLat <= dirNext;
  end

  assign quadA = gray[1];
  assign quadB = gray[0];

endmodule
